// File: rtl/uart_prog_loader_if.sv
// Memory program-port bundle driven by the UART boot loader.
//   upg_clk_o  : clock for the memory program port (copy of the loader clock)
//   upg_wen_o  : one-cycle write strobe
//   upg_adr_o  : word address of the current write
//   upg_dat_o  : 32-bit word of the current write
//   upg_done_o : sticky load-complete flag
// master = loader side, slave = program ROM / data RAM side.
interface uart_prog_loader_if #(
  parameter int ADR_W = 15
);
  logic             upg_clk_o;
  logic             upg_wen_o;
  logic [ADR_W-1:0] upg_adr_o;
  logic [31:0]      upg_dat_o;
  logic             upg_done_o;

  modport master (
    output upg_clk_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o
  );

  modport slave (
    input upg_clk_o, upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o
  );
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot-programmer front end.
// Receives 8N1 bytes: a 16-bit little-endian word count N, then N
// little-endian 32-bit words. Each word is written to the program port with
// an auto-incrementing address; afterwards done is raised and ACK_BYTE is
// transmitted. Framing or length errors send ERR_BYTE and lock up until reset.
// Ports:
//   upg_clk_i : clock, rising edge
//   upg_rst_i : synchronous reset, active low
//   upg_rx_i  : asynchronous UART receive line (idle high)
//   upg_tx_o  : UART transmit line (idle high)
//   prog      : memory program port (uart_prog_loader_if.master)
module uart_prog_loader #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         ADR_W        = 15,
  parameter logic [7:0] ACK_BYTE     = 8'h4F,
  parameter logic [7:0] ERR_BYTE     = 8'h45
) (
  input  logic               upg_clk_i,
  input  logic               upg_rst_i,
  input  logic               upg_rx_i,
  output logic               upg_tx_o,
  uart_prog_loader_if.master prog
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Common width for comparing the 16-bit length against word counts.
  localparam int               CW        = (ADR_W + 1 > 16) ? ADR_W + 1 : 16;
  localparam logic [CW-1:0]    MAX_WORDS = CW'(1) << ADR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_ACK, S_DONE, S_ERR} state_t;

  // Receiver
  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t        rx_state_r;
  logic [CNT_W-1:0] rx_cnt_r;
  logic [2:0]       rx_bit_r;
  logic [7:0]       rx_shift_r;
  logic [7:0]       rx_byte_r;
  logic             byte_valid_r, frame_err_r;

  // Parser
  state_t           state_r, state_s;
  logic [15:0]      len_r, len_s;
  logic [15:0]      len_full_s;
  logic [ADR_W:0]   word_cnt_r, word_cnt_s, word_inc_s;
  logic             word_last_s;
  logic [1:0]       byte_cnt_r, byte_cnt_s;
  logic [23:0]      asm_r, asm_s;
  logic             wen_r, wen_s;
  logic [ADR_W-1:0] adr_r, adr_s;
  logic [31:0]      dat_r, dat_s;
  logic             done_r, done_s;

  // Transmitter
  logic             tx_go_s;
  logic [7:0]       tx_byte_s;
  logic             tx_r, tx_busy_r, tx_launched_r;
  logic [9:0]       tx_shift_r;
  logic [3:0]       tx_bit_r;
  logic [CNT_W-1:0] tx_cnt_r;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= upg_rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // 8N1 receiver: mid-bit sampling, false-start rejection, one-cycle pulses
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_i) begin
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= '0;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'h00;
      rx_byte_r    <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= '0;
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            // A line already back high at mid start-bit was a glitch.
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= '0;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
              rx_byte_r    <= rx_shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + CNT_W'(1);
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  assign len_full_s  = {rx_byte_r, len_r[7:0]};
  assign word_inc_s  = word_cnt_r + {{ADR_W{1'b0}}, 1'b1};
  assign word_last_s = (CW'(word_inc_s) == CW'(len_r));

  // Parser state register
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_i) begin
      state_r <= S_LEN0;
    end else begin
      state_r <= state_s;
    end
  end

  // Parser next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_LEN0: begin
        if (frame_err_r) state_s = S_ERR;
        else if (byte_valid_r) state_s = S_LEN1;
        else state_s = state_r;
      end
      S_LEN1: begin
        if (frame_err_r) state_s = S_ERR;
        else if (byte_valid_r) begin
          if (len_full_s == 16'd0) state_s = S_ACK;
          else if (CW'(len_full_s) > MAX_WORDS) state_s = S_ERR;
          else state_s = S_DATA;
        end else state_s = state_r;
      end
      S_DATA: begin
        if (frame_err_r) state_s = S_ERR;
        else if (byte_valid_r && (byte_cnt_r == 2'd3) && word_last_s) state_s = S_ACK;
        else state_s = state_r;
      end
      S_ACK: begin
        // Leave once the ACK frame has been launched and fully shifted out.
        if (tx_launched_r && !tx_busy_r) state_s = S_DONE;
        else state_s = state_r;
      end
      S_DONE:  state_s = S_DONE;
      S_ERR:   state_s = S_ERR;
      default: state_s = S_LEN0;
    endcase
  end

  // Parser outputs: next values of the datapath and the TX launch request
  always_comb begin
    len_s      = len_r;
    word_cnt_s = word_cnt_r;
    byte_cnt_s = byte_cnt_r;
    asm_s      = asm_r;
    wen_s      = 1'b0;
    adr_s      = adr_r;
    dat_s      = dat_r;
    done_s     = done_r;
    tx_go_s    = 1'b0;
    tx_byte_s  = ACK_BYTE;
    case (state_r)
      S_LEN0: begin
        if (byte_valid_r) len_s = {len_r[15:8], rx_byte_r};
        else len_s = len_r;
      end
      S_LEN1: begin
        if (byte_valid_r) begin
          len_s  = len_full_s;
          done_s = (len_full_s == 16'd0);
        end else begin
          len_s = len_r;
        end
      end
      S_DATA: begin
        if (byte_valid_r) begin
          byte_cnt_s = byte_cnt_r + 2'd1;
          case (byte_cnt_r)
            2'd0: asm_s[7:0]   = rx_byte_r;
            2'd1: asm_s[15:8]  = rx_byte_r;
            2'd2: asm_s[23:16] = rx_byte_r;
            default: begin
              // Fourth byte completes the word: write it next cycle.
              wen_s      = 1'b1;
              adr_s      = word_cnt_r[ADR_W-1:0];
              dat_s      = {rx_byte_r, asm_r};
              word_cnt_s = word_inc_s;
              done_s     = word_last_s;
            end
          endcase
        end else begin
          byte_cnt_s = byte_cnt_r;
        end
      end
      S_ACK: begin
        tx_go_s   = !tx_launched_r;
        tx_byte_s = ACK_BYTE;
      end
      S_ERR: begin
        tx_go_s   = !tx_launched_r;
        tx_byte_s = ERR_BYTE;
      end
      S_DONE:  tx_go_s = 1'b0;
      default: tx_go_s = 1'b0;
    endcase
  end

  // Parser datapath registers (all program-port outputs are registered)
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_i) begin
      len_r      <= 16'd0;
      word_cnt_r <= '0;
      byte_cnt_r <= 2'd0;
      asm_r      <= 24'd0;
      wen_r      <= 1'b0;
      adr_r      <= '0;
      dat_r      <= 32'd0;
      done_r     <= 1'b0;
    end else begin
      len_r      <= len_s;
      word_cnt_r <= word_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      asm_r      <= asm_s;
      wen_r      <= wen_s;
      adr_r      <= adr_s;
      dat_r      <= dat_s;
      done_r     <= done_s;
    end
  end

  // 8N1 transmitter: one frame per launch, line parks high afterwards
  always_ff @(posedge upg_clk_i) begin
    if (!upg_rst_i) begin
      tx_r          <= 1'b1;
      tx_busy_r     <= 1'b0;
      tx_launched_r <= 1'b0;
      tx_shift_r    <= 10'h3FF;
      tx_bit_r      <= 4'd0;
      tx_cnt_r      <= '0;
    end else if (tx_go_s) begin
      tx_shift_r    <= {1'b1, tx_byte_s, 1'b0};
      tx_r          <= 1'b0;
      tx_busy_r     <= 1'b1;
      tx_launched_r <= 1'b1;
      tx_bit_r      <= 4'd0;
      tx_cnt_r      <= '0;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == BIT_LAST) begin
        tx_cnt_r <= '0;
        if (tx_bit_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          tx_r      <= 1'b1;
        end else begin
          tx_bit_r   <= tx_bit_r + 4'd1;
          tx_r       <= tx_shift_r[1];
          tx_shift_r <= {1'b1, tx_shift_r[9:1]};
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + CNT_W'(1);
      end
    end
  end

  assign prog.upg_clk_o  = upg_clk_i;
  assign prog.upg_wen_o  = wen_r;
  assign prog.upg_adr_o  = adr_r;
  assign prog.upg_dat_o  = dat_r;
  assign prog.upg_done_o = done_r;
  assign upg_tx_o        = tx_r;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader (CLKS_PER_BIT = 16, ADR_W = 15).
// Directed table cases, two hand-written multi-cycle sequences and randomized
// byte streams checked against a byte-level reference model.
module tb_uart_prog_loader;
  localparam int CPB   = 16;
  localparam int ADR_W = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;

  uart_prog_loader_if #(.ADR_W(ADR_W)) prog_if ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADR_W       (ADR_W),
    .ACK_BYTE    (8'h4F),
    .ERR_BYTE    (8'h45)
  ) dut (
    .upg_clk_i(clk),
    .upg_rst_i(rst_n),
    .upg_rx_i (rx),
    .upg_tx_o (tx),
    .prog     (prog_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Observed and expected traffic
  logic [46:0] wr_q[$];   // {adr, dat}
  logic [8:0]  tx_q[$];   // {stop, byte}
  logic [46:0] exp_wr[$];
  logic        exp_done;
  int          exp_tx;
  logic [7:0]  stim_b[$];
  bit          stim_bad[$];

  typedef struct packed {
    logic [3:0]  n;
    logic [95:0] bytes;   // byte i at [95-8*i -: 8]
    logic [11:0] bad;     // bit i: byte i sent with stop bit 0
    logic [1:0]  nwr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        done;
    logic        has_tx;
    logic [7:0]  tx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Write-strobe monitor
  always @(negedge clk) begin
    if (rst_n && prog_if.upg_wen_o === 1'b1)
      wr_q.push_back({prog_if.upg_adr_o, prog_if.upg_dat_o});
  end

  // TX line decoder
  initial begin
    logic [7:0] b;
    logic       stp;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stp = tx;
        tx_q.push_back({stp, b});
      end
    end
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad ? 1'b0 : 1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], stim_bad[i]);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rst_wen"},  {63'd0, prog_if.upg_wen_o},  64'd0);
    chk({tag, "_rst_adr"},  {49'd0, prog_if.upg_adr_o},  64'd0);
    chk({tag, "_rst_dat"},  {32'd0, prog_if.upg_dat_o},  64'd0);
    chk({tag, "_rst_done"}, {63'd0, prog_if.upg_done_o}, 64'd0);
    chk({tag, "_rst_tx"},   {63'd0, tx},                 64'd1);
  endtask

  task automatic apply_reset(input string tag);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset(tag);
    rst_n = 1'b1;
    wr_q.delete();
    tx_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic settle();
    repeat (30 * CPB) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (i < wr_q.size()) chk({tag, "_wr"}, {17'd0, wr_q[i]}, {17'd0, exp_wr[i]});
    chk({tag, "_done"}, {63'd0, prog_if.upg_done_o}, {63'd0, exp_done});
    chk({tag, "_tx_count"}, 64'(tx_q.size()), (exp_tx >= 0) ? 64'd1 : 64'd0);
    if (exp_tx >= 0 && tx_q.size() > 0)
      chk({tag, "_tx_byte"}, {55'd0, tx_q[0]}, {55'd0, 1'b1, exp_tx[7:0]});
  endtask

  // Reference model: interpret the byte stream by the protocol rules.
  task automatic model_run();
    int n;
    int nb;
    int words;
    logic [31:0] w;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_tx = -1;
    n = 0; nb = 0; words = 0; w = 32'd0;
    for (int i = 0; i < stim_b.size(); i++) begin
      if (stim_bad[i]) begin
        exp_tx = 8'h45;
        break;
      end
      if (i == 0) begin
        n = int'(stim_b[i]);
      end else if (i == 1) begin
        n = n + 256 * int'(stim_b[i]);
        if (n == 0) begin
          exp_done = 1'b1; exp_tx = 8'h4F; break;
        end
        if (n > (1 << ADR_W)) begin
          exp_tx = 8'h45; break;
        end
      end else begin
        w = w | (32'(stim_b[i]) << (8 * nb));
        nb++;
        if (nb == 4) begin
          exp_wr.push_back({15'(words), w});
          words++; nb = 0; w = 32'd0;
          if (words == n) begin
            exp_done = 1'b1; exp_tx = 8'h4F; break;
          end
        end
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [7:0] hi;
    int nw;
    vecs[0] = '{4'd12, {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h11, 8'h22},
                12'h000, 2'd2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b1, 8'h4F};
    vecs[1] = '{4'd2, {8'h00, 8'h00, 80'd0}, 12'h000, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 8'h4F};
    vecs[2] = '{4'd6, {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 48'd0}, 12'h010,
                2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 8'h45};
    vecs[3] = '{4'd2, {8'h01, 8'h80, 80'd0}, 12'h000, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1, 8'h45};
    // N = 2^ADR_W exactly is legal: data is accepted, load stays open.
    vecs[4] = '{4'd6, {8'h00, 8'h80, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 48'd0}, 12'h000,
                2'd1, 32'hD4C3B2A1, 32'd0, 1'b0, 1'b0, 8'h00};

    apply_reset("init");
    @(posedge clk); #1;
    chk("clk_o_high", {63'd0, prog_if.upg_clk_o}, 64'd1);
    @(negedge clk); #1;
    chk("clk_o_low", {63'd0, prog_if.upg_clk_o}, 64'd0);

    // Directed table
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      stim_b.delete(); stim_bad.delete();
      for (int i = 0; i < int'(v.n); i++) begin
        stim_b.push_back(v.bytes[95 - 8 * i -: 8]);
        stim_bad.push_back(v.bad[i]);
      end
      exp_wr.delete();
      if (v.nwr >= 2'd1) exp_wr.push_back({15'd0, v.d0});
      if (v.nwr == 2'd2) exp_wr.push_back({15'd1, v.d1});
      exp_done = v.done;
      exp_tx = v.has_tx ? int'(v.tx) : -1;
      apply_reset($sformatf("vec%0d", k));
      send_stim();
      settle();
      compare($sformatf("vec%0d", k));
    end

    // Glitch rejection: short low pulse must not start a frame
    apply_reset("glitch");
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    stim_b = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    stim_bad = '{0, 0, 0, 0, 0, 0};
    send_stim();
    settle();
    exp_wr.delete();
    exp_wr.push_back({15'd0, 32'hDDCCBBAA});
    exp_done = 1'b1;
    exp_tx = 8'h4F;
    compare("glitch");

    // Reset in the middle of a word discards the partial word
    apply_reset("midrst");
    stim_b = '{8'h01, 8'h00, 8'h11, 8'h22};
    stim_bad = '{0, 0, 0, 0};
    send_stim();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst_pulse");
    rst_n = 1'b1;
    wr_q.delete();
    tx_q.delete();
    repeat (4) @(negedge clk);
    stim_b = '{8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    stim_bad = '{0, 0, 0, 0, 0, 0};
    send_stim();
    settle();
    exp_wr.delete();
    exp_wr.push_back({15'd0, 32'hD4C3B2A1});
    exp_done = 1'b1;
    exp_tx = 8'h4F;
    compare("midrst");

    // Randomized streams against the reference model
    for (int r = 0; r < 6; r++) begin
      stim_b.delete(); stim_bad.delete();
      nw = $urandom_range(0, 3);
      hi = ($urandom_range(0, 4) == 0) ? (8'h80 | 8'($urandom_range(0, 255))) : 8'h00;
      stim_b.push_back(8'(nw)); stim_bad.push_back(0);
      stim_b.push_back(hi);     stim_bad.push_back(0);
      for (int i = 0; i < 4 * nw + int'($urandom_range(0, 2)); i++) begin
        stim_b.push_back(8'($urandom_range(0, 255)));
        stim_bad.push_back(0);
      end
      if ($urandom_range(0, 2) == 0)
        stim_bad[$urandom_range(0, stim_b.size() - 1)] = 1;
      model_run();
      apply_reset($sformatf("rnd%0d", r));
      send_stim();
      settle();
      compare($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
